ecc_secded_pipe: RTL and testbench
==================================

// Module: ecc_secded_pipe
// PURPOSE
//  Parametrised, pipelined SECDED (Hamming + overall parity) encode/decode engine with valid/ready streaming.
//  Per-beat op selects encode or decode. Keeps saturating error counters and a sticky first-uncorrectable log.
//  Sits between memory controller datapath and SRAM macros; supersedes fixed-64-bit combinational ECC.
// PARAMETERS
//  DATA_WIDTH   64  data bits per beat, 4..256
//  COUNT_WIDTH  16  width of each saturating error counter
//  (local) R = min r with 2^r >= DATA_WIDTH+r+1 (7 @64); CODE_WIDTH = DATA_WIDTH+R+1 (72 @64)
// PORTS
//  clk            in   1           clock, rising edge
//  rst_n          in   1           async active-low reset
//  in_valid       in   1           input beat valid
//  in_ready       out  1           input beat accepted when in_valid&in_ready
//  in_op          in   1           0=encode, 1=decode
//  in_code        in   CODE_WIDTH  encode: data in [DATA_WIDTH-1:0], upper bits ignored; decode: codeword
//  out_valid      out  1           output beat valid
//  out_ready      in   1           downstream accept
//  out_code       out  CODE_WIDTH  encode: codeword; decode: corrected codeword
//  out_data       out  DATA_WIDTH  corrected data (encode: copy of input data)
//  out_syndrome   out  R+1         {overall parity, syndrome}; 0 for encode beats
//  out_corrected  out  1           decode beat had single error, corrected
//  out_uncorr     out  1           decode beat had uncorrectable error
//  cnt_clr        in   1           sync pulse: clear counters and log
//  corr_count     out  COUNT_WIDTH correctable-error count, saturating
//  uncorr_count   out  COUNT_WIDTH uncorrectable-error count, saturating
//  log_valid      out  1           sticky: uncorrectable seen since clear
//  log_syndrome   out  R+1         {ov,syndrome} of first uncorrectable since clear
// BEHAVIOUR
//  Code layout: [DATA_WIDTH-1:0] data; [DATA_WIDTH+R-1:DATA_WIDTH] check c[R-1:0]; [CODE_WIDTH-1] overall parity P.
//  Data bit i has Hamming position h(i) = i-th integer >=3 not a power of 2 (3,5,6,7,9,10,...).
//  c[j] = XOR of data bits i with h(i)[j]=1. Check bit c[j] has position 2^j. P = XOR of data and c (even total).
//  Decode: s[j] = received c[j] ^ recomputed c[j]; ov = XOR of all CODE_WIDTH bits.
//   s=0,ov=0: clean. ov=1,s=0: P bit flipped, corrected.
//   ov=1, s=2^j: c[j] flipped, corrected. ov=1, s=h(i): data bit i flipped, corrected.
//   ov=1, s matches no position: uncorrectable. ov=0, s!=0: double error, uncorrectable.
//  Uncorrectable: out_data/out_code = received bits unmodified.
//  Pipeline: stage1 registers input and syndrome/ov. Stage2 registers correction, flags, outputs.
//   Latency 2 cycles accept->out_valid. Throughput 1 beat/cycle while out_ready=1.
//  Handshake: in_ready = !s1_valid | s1 advances. s1 advances when !s2_valid | out_ready.
//   out_* stable while out_valid & !out_ready. No beat dropped or reordered.
//   in_ready is combinational from out_ready; no other comb path in->out.
//  Counters update on stage2 load of decode beat (not on output handshake).
//   Saturate at all-ones. Encode beats never count.
//  cnt_clr: counters->0, log_valid->0. Priority over same-cycle event; that event is not counted or logged.
//  log_syndrome captured only when log_valid=0 and an uncorrectable beat loads stage2. Holds until cnt_clr.
//  Reset (any cycle, incl. mid-stream): in-flight beats discarded.
//   out_valid=0, pipeline valids=0, counters=0, log_valid=0, log_syndrome=0, out_* data regs=0.
//   in_ready=1 from first cycle after reset release.
// TESTING (DATA_WIDTH=64 unless noted)
//  Encode data 64'h1 -> out_code=72'h83_0000_0000_0000_0001, out_valid 2 cycles after accept. Encode 0 -> 0.
//  Decode 72'h83_0000_0000_0000_0021 (bit5 flipped) -> out_data=64'h1, out_corrected=1, out_syndrome={1,7'd10}, corr_count=1.
//  Decode 72'h83_0000_0000_0000_0002 (bits0,1 flipped) -> out_uncorr=1, syndrome {0,7'd6}.
//   uncorr_count=1, log_valid=1, log_syndrome=8'h06. Second uncorrectable leaves log unchanged.
//  Stream 4 beats, out_ready=0 for 5 cycles -> 2 beats accepted, in_ready=0. Release -> 4 beats out in order, data intact.
//  COUNT_WIDTH=4, 17 correctable beats -> corr_count=15. cnt_clr same cycle as a correctable beat -> corr_count=0.
//  Assert rst_n low with 2 beats in flight -> out_valid=0, counters=0 immediately. Post-release encode works, no stale beat.

Source files
------------

// File: rtl/ecc_secded_pipe.sv
// rtl/ecc_secded_pipe.sv - two-stage SECDED encode/decode pipeline with valid/ready streaming
// Stage 1 computes check bits and syndrome, stage 2 applies the correction and updates counters and the log.
module ecc_secded_pipe #(
  parameter  int DATA_WIDTH  = 64,
  parameter  int COUNT_WIDTH = 16,
  localparam int R           = $clog2(DATA_WIDTH + $clog2(DATA_WIDTH + 1) + 1),
  localparam int CODE_WIDTH  = DATA_WIDTH + R + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_op,
  input  logic [CODE_WIDTH-1:0]  in_code,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CODE_WIDTH-1:0]  out_code,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [R:0]             out_syndrome,
  output logic                   out_corrected,
  output logic                   out_uncorr,
  input  logic                   cnt_clr,
  output logic [COUNT_WIDTH-1:0] corr_count,
  output logic [COUNT_WIDTH-1:0] uncorr_count,
  output logic                   log_valid,
  output logic [R:0]             log_syndrome
);

  localparam int NPOS = DATA_WIDTH + R;

  // Walk Hamming positions 3..NPOS; non-powers of two map to consecutive data bits.
  function automatic logic [R-1:0] calc_check(input logic [DATA_WIDTH-1:0] d);
    logic [R-1:0] c;
    int k;
    c = '0;
    k = 0;
    for (int p = 3; p <= NPOS; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[k]) c = c ^ R'(p);
        k++;
      end
    end
    return c;
  endfunction

  // Code bit whose Hamming position equals s; syndrome 0 points at the overall parity bit.
  function automatic logic [CODE_WIDTH-1:0] flip_mask(input logic [R-1:0] s);
    logic [CODE_WIDTH-1:0] m;
    int k;
    int j;
    m = '0;
    k = 0;
    j = 0;
    if (s == '0) m[CODE_WIDTH-1] = 1'b1;
    for (int p = 1; p <= NPOS; p++) begin
      if ((p & (p - 1)) == 0) begin
        if (s == R'(p)) m[DATA_WIDTH + j] = 1'b1;
        j++;
      end else begin
        if (s == R'(p)) m[k] = 1'b1;
        k++;
      end
    end
    return m;
  endfunction

  logic                   s1_valid_q, s1_op_q, s1_ov_q;
  logic [CODE_WIDTH-1:0]  s1_code_q;
  logic [R-1:0]           s1_syn_q;
  logic                   s2_valid_q, s2_corr_q, s2_unc_q;
  logic [CODE_WIDTH-1:0]  s2_code_q;
  logic [R:0]             s2_syn_q;
  logic [COUNT_WIDTH-1:0] corr_q, unc_q;
  logic                   log_valid_q;
  logic [R:0]             log_syn_q;

  logic                   s1_adv;
  logic [DATA_WIDTH-1:0]  in_data;
  logic [R-1:0]           in_chk;
  logic [CODE_WIDTH-1:0]  s1_code_d;
  logic [R-1:0]           s1_syn_d;
  logic                   s1_ov_d;
  logic [CODE_WIDTH-1:0]  mask;
  logic                   s2_corr_d, s2_unc_d;
  logic [CODE_WIDTH-1:0]  s2_code_d;
  logic [R:0]             s2_syn_d;

  assign s1_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;

  always_comb begin
    in_data   = in_code[DATA_WIDTH-1:0];
    in_chk    = calc_check(in_data);
    s1_code_d = {^{in_data, in_chk}, in_chk, in_data};
    s1_syn_d  = '0;
    s1_ov_d   = 1'b0;
    if (in_op) begin
      s1_code_d = in_code;
      s1_syn_d  = in_code[DATA_WIDTH+R-1:DATA_WIDTH] ^ in_chk;
      s1_ov_d   = ^in_code;
    end
  end

  // Uncorrectable beats pass the received word through untouched.
  always_comb begin
    mask      = flip_mask(s1_syn_q);
    s2_corr_d = s1_op_q && s1_ov_q && (|mask);
    s2_unc_d  = s1_op_q && (s1_ov_q ? ~(|mask) : (|s1_syn_q));
    s2_code_d = s2_corr_d ? (s1_code_q ^ mask) : s1_code_q;
    s2_syn_d  = {s1_ov_q, s1_syn_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= 1'b0;
      s1_ov_q    <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_op_q   <= in_op;
        s1_ov_q   <= s1_ov_d;
        s1_code_q <= s1_code_d;
        s1_syn_q  <= s1_syn_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_corr_q  <= 1'b0;
      s2_unc_q   <= 1'b0;
      s2_code_q  <= '0;
      s2_syn_q   <= '0;
    end else if (s1_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_corr_q <= s2_corr_d;
        s2_unc_q  <= s2_unc_d;
        s2_code_q <= s2_code_d;
        s2_syn_q  <= s2_syn_d;
      end
    end
  end

  // Statistics follow stage-2 loads; a same-cycle clear wins and drops the event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_q      <= '0;
      unc_q       <= '0;
      log_valid_q <= 1'b0;
      log_syn_q   <= '0;
    end else if (cnt_clr) begin
      corr_q      <= '0;
      unc_q       <= '0;
      log_valid_q <= 1'b0;
      log_syn_q   <= '0;
    end else if (s1_adv && s1_valid_q) begin
      if (s2_corr_d && corr_q != '1) corr_q <= corr_q + COUNT_WIDTH'(1);
      if (s2_unc_d) begin
        if (unc_q != '1) unc_q <= unc_q + COUNT_WIDTH'(1);
        if (!log_valid_q) begin
          log_valid_q <= 1'b1;
          log_syn_q   <= s2_syn_d;
        end
      end
    end
  end

  assign out_valid     = s2_valid_q;
  assign out_code      = s2_code_q;
  assign out_data      = s2_code_q[DATA_WIDTH-1:0];
  assign out_syndrome  = s2_syn_q;
  assign out_corrected = s2_corr_q;
  assign out_uncorr    = s2_unc_q;
  assign corr_count    = corr_q;
  assign uncorr_count  = unc_q;
  assign log_valid     = log_valid_q;
  assign log_syndrome  = log_syn_q;

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// tb/tb_ecc_secded_pipe.sv - self-checking bench for ecc_secded_pipe
module tb_ecc_secded_pipe;
  localparam int DW = 64;
  localparam int R  = 7;
  localparam int CW = 72;
  localparam int NV = 11;

  typedef struct {
    logic          op;
    logic [CW-1:0] code_in;
    logic [CW-1:0] exp_code;
    logic [DW-1:0] exp_data;
    logic [R:0]    exp_syn;
    logic          exp_corr;
    logic          exp_unc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          m_in_valid, m_in_ready, m_in_op, m_out_valid, m_out_ready;
  logic [CW-1:0] m_in_code, m_out_code;
  logic [DW-1:0] m_out_data;
  logic [R:0]    m_out_syndrome, m_log_syndrome;
  logic          m_out_corrected, m_out_uncorr, m_cnt_clr, m_log_valid;
  logic [15:0]   m_corr_count, m_uncorr_count;

  logic          s_in_valid, s_in_ready, s_in_op, s_out_valid, s_out_ready;
  logic [CW-1:0] s_in_code, s_out_code;
  logic [DW-1:0] s_out_data;
  logic [R:0]    s_out_syndrome, s_log_syndrome;
  logic          s_out_corrected, s_out_uncorr, s_cnt_clr, s_log_valid;
  logic [3:0]    s_corr_count, s_uncorr_count;

  ecc_secded_pipe #(.DATA_WIDTH(DW), .COUNT_WIDTH(16)) u_main (
    .clk(clk), .rst_n(rst_n),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .in_op(m_in_op), .in_code(m_in_code),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .out_code(m_out_code), .out_data(m_out_data),
    .out_syndrome(m_out_syndrome), .out_corrected(m_out_corrected), .out_uncorr(m_out_uncorr),
    .cnt_clr(m_cnt_clr), .corr_count(m_corr_count), .uncorr_count(m_uncorr_count),
    .log_valid(m_log_valid), .log_syndrome(m_log_syndrome)
  );

  ecc_secded_pipe #(.DATA_WIDTH(DW), .COUNT_WIDTH(4)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_op(s_in_op), .in_code(s_in_code),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_code(s_out_code), .out_data(s_out_data),
    .out_syndrome(s_out_syndrome), .out_corrected(s_out_corrected), .out_uncorr(s_out_uncorr),
    .cnt_clr(s_cnt_clr), .corr_count(s_corr_count), .uncorr_count(s_uncorr_count),
    .log_valid(s_log_valid), .log_syndrome(s_log_syndrome)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         hp[DW];
  int         e_corr, e_unc, lat, stale;
  logic       e_logv;
  logic [R:0] e_logs;
  vec_t       tbl[NV];
  vec_t       sv, su, b0, b1;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int code_pos(int b);
    if (b < DW) return hp[b];
    if (b < CW - 1) return 1 << (b - DW);
    return 0;
  endfunction

  // Check bits are the XOR of the Hamming positions of all set data bits.
  function automatic logic [CW-1:0] m_enc(logic [DW-1:0] d);
    int c;
    logic [CW-1:0] w;
    c = 0;
    for (int i = 0; i < DW; i++) if (d[i]) c ^= hp[i];
    w = {1'b0, c[R-1:0], d};
    w[CW-1] = ^w;
    return w;
  endfunction

  function automatic vec_t make_enc(logic [CW-1:0] raw);
    vec_t v;
    v.op       = 1'b0;
    v.code_in  = raw;
    v.exp_code = m_enc(raw[DW-1:0]);
    v.exp_data = raw[DW-1:0];
    v.exp_syn  = '0;
    v.exp_corr = 1'b0;
    v.exp_unc  = 1'b0;
    return v;
  endfunction

  // Syndrome is the XOR of flipped positions; overall parity is the flip count parity.
  function automatic vec_t make_dec(logic [DW-1:0] d, int nf, int f0, int f1, int f2);
    vec_t v;
    logic [CW-1:0] cw;
    int fl[3];
    int s;
    fl = '{f0, f1, f2};
    s = 0;
    cw = m_enc(d);
    v.op = 1'b1;
    v.code_in = cw;
    for (int i = 0; i < nf; i++) begin
      v.code_in[fl[i]] = ~v.code_in[fl[i]];
      s ^= code_pos(fl[i]);
    end
    v.exp_syn  = {1'(nf % 2), s[R-1:0]};
    v.exp_corr = (nf == 1);
    v.exp_unc  = (nf >= 2);
    v.exp_code = v.exp_unc ? v.code_in : cw;
    v.exp_data = v.exp_code[DW-1:0];
    return v;
  endfunction

  task automatic do_beat(input logic op, input logic [CW-1:0] code, output int l);
    @(negedge clk);
    m_in_valid = 1'b1; m_in_op = op; m_in_code = code; m_out_ready = 1'b1;
    @(posedge clk);
    l = 0;
    do begin
      @(negedge clk);
      m_in_valid = 1'b0;
      l++;
    end while (!m_out_valid && l < 10);
  endtask

  task automatic s_beat(input logic [CW-1:0] code, input logic clr);
    @(negedge clk);
    s_in_valid = 1'b1; s_in_op = 1'b1; s_in_code = code; s_out_ready = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0; s_cnt_clr = clr;
    @(negedge clk);
    s_cnt_clr = 1'b0;
    chk("sat beat out_valid", 160'(s_out_valid), 160'(1));
  endtask

  task automatic stream(input int nb, input int stall, input int rdy_pct, input int vld_pct, input bit dec_en);
    vec_t q[$];
    vec_t v;
    logic [DW-1:0] d;
    int k, nout, cyc, nf, a, b;
    bit hold;
    k = 0; nout = 0; cyc = 0; hold = 0;
    for (int i = 0; i < nb; i++) begin
      d = {$urandom, $urandom};
      if (dec_en && $urandom_range(1) == 1) begin
        nf = int'($urandom_range(2));
        a  = int'($urandom_range(CW - 1));
        b  = (a + 1 + int'($urandom_range(CW - 2))) % CW;
        v  = make_dec(d, nf, a, b, 0);
      end else begin
        v = make_enc({8'($urandom), d});
      end
      if (v.exp_corr) e_corr++;
      if (v.exp_unc) begin
        e_unc++;
        if (!e_logv) begin e_logv = 1'b1; e_logs = v.exp_syn; end
      end
      q.push_back(v);
    end
    m_in_valid = 1'b0;
    while (nout < nb && cyc < nb * 20 + 50) begin
      @(negedge clk);
      if (stall > 0 && cyc == stall) begin
        #1;
        chk("stall beats accepted", 160'(k), 160'(2));
        chk("stall in_ready", 160'(m_in_ready), 160'(0));
      end
      m_out_ready = (cyc < stall) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      if (!hold) m_in_valid = (k < nb) && ($urandom_range(99) < vld_pct);
      if (k < nb) begin m_in_op = q[k].op; m_in_code = q[k].code_in; end
      #1;
      if (m_out_valid && m_out_ready) begin
        chk($sformatf("stream beat %0d", nout),
            {m_out_code, m_out_data, m_out_syndrome, m_out_corrected, m_out_uncorr},
            {q[nout].exp_code, q[nout].exp_data, q[nout].exp_syn, q[nout].exp_corr, q[nout].exp_unc});
        nout++;
      end
      hold = m_in_valid && !m_in_ready;
      if (m_in_valid && m_in_ready) k++;
      cyc++;
    end
    m_in_valid = 1'b0;
    m_out_ready = 1'b1;
    chk("stream complete", 160'(nout), 160'(nb));
  endtask

  initial begin
    int p;
    p = 2;
    for (int i = 0; i < DW; i++) begin
      do p++; while ((p & (p - 1)) == 0);
      hp[i] = p;
    end

    m_in_valid = 0; m_in_op = 0; m_in_code = '0; m_out_ready = 1; m_cnt_clr = 0;
    s_in_valid = 0; s_in_op = 0; s_in_code = '0; s_out_ready = 1; s_cnt_clr = 0;

    tbl[0]  = make_enc({8'hA5, 64'h1});
    tbl[0].exp_code = 72'h83_0000_0000_0000_0001;
    tbl[1]  = make_enc({8'hFF, 64'h0});
    tbl[1].exp_code = '0;
    tbl[2]  = '{1'b1, 72'h83_0000_0000_0000_0021, 72'h83_0000_0000_0000_0001, 64'h1, 8'h8A, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 72'h83_0000_0000_0000_0002, 72'h83_0000_0000_0000_0002, 64'h2, 8'h06, 1'b0, 1'b1};
    tbl[4]  = make_dec(64'hDEAD_BEEF_0123_4567, 2, 10, 40, 0);
    tbl[5]  = make_dec(64'h0F0F_1234_8888_0001, 1, 71, 0, 0);
    tbl[6]  = make_dec(64'h5555_AAAA_0000_FFFF, 1, 66, 0, 0);
    tbl[7]  = make_dec(64'h7000_0000_0000_0003, 1, 63, 0, 0);
    tbl[8]  = make_dec(64'h1357_9BDF_2468_ACE0, 3, 70, 67, 71);
    tbl[9]  = make_dec(64'hFEDC_BA98_7654_3210, 0, 0, 0, 0);
    tbl[10] = make_enc({8'h00, 64'hFFFF_FFFF_FFFF_FFFF});

    repeat (3) @(negedge clk);
    chk("reset out_valid", 160'(m_out_valid), 160'(0));
    chk("reset stats", {m_corr_count, m_uncorr_count, m_log_valid, m_log_syndrome, m_out_code}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready after reset", 160'(m_in_ready), 160'(1));

    e_corr = 0; e_unc = 0; e_logv = 1'b0; e_logs = '0;
    for (int i = 0; i < NV; i++) begin
      do_beat(tbl[i].op, tbl[i].code_in, lat);
      if (i == 0) chk("latency", 160'(lat), 160'(2));
      chk($sformatf("vec%0d out", i),
          {m_out_code, m_out_data, m_out_syndrome, m_out_corrected, m_out_uncorr},
          {tbl[i].exp_code, tbl[i].exp_data, tbl[i].exp_syn, tbl[i].exp_corr, tbl[i].exp_unc});
      if (tbl[i].exp_corr) e_corr++;
      if (tbl[i].exp_unc) begin
        e_unc++;
        if (!e_logv) begin e_logv = 1'b1; e_logs = tbl[i].exp_syn; end
      end
      chk($sformatf("vec%0d stats", i), {m_corr_count, m_uncorr_count, m_log_valid, m_log_syndrome},
          {16'(e_corr), 16'(e_unc), e_logv, e_logs});
    end

    @(negedge clk); m_cnt_clr = 1'b1;
    @(negedge clk); m_cnt_clr = 1'b0;
    chk("cnt_clr", {m_corr_count, m_uncorr_count, m_log_valid}, '0);

    stream(4, 5, 100, 100, 1'b0);

    e_corr = 0; e_unc = 0; e_logv = 1'b0; e_logs = '0;
    stream(200, 0, 70, 70, 1'b1);
    @(negedge clk);
    chk("random stats", {m_corr_count, m_uncorr_count, m_log_valid, m_log_syndrome},
        {16'(e_corr), 16'(e_unc), e_logv, e_logs});

    sv = make_dec(64'h0000_1234_5678_9ABC, 1, 5, 0, 0);
    su = make_dec(64'h0000_0000_FFFF_0000, 2, 3, 68, 0);
    @(negedge clk);
    s_in_valid = 1'b1; s_in_op = 1'b1; s_in_code = sv.code_in;
    repeat (17) @(negedge clk);
    s_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("sat corr_count", {s_corr_count, s_uncorr_count}, {4'd15, 4'd0});
    @(negedge clk); s_cnt_clr = 1'b1;
    @(negedge clk); s_cnt_clr = 1'b0;
    chk("sat clear", {s_corr_count, s_uncorr_count, s_log_valid}, '0);
    s_beat(sv.code_in, 1'b0);
    chk("sat one corr", 160'(s_corr_count), 160'(1));
    s_beat(sv.code_in, 1'b1);
    chk("clr beats corr", {s_out_corrected, s_corr_count}, {1'b1, 4'd0});
    s_beat(su.code_in, 1'b1);
    chk("clr beats uncorr", {s_out_uncorr, s_uncorr_count, s_log_valid}, {1'b1, 4'd0, 1'b0});
    s_beat(su.code_in, 1'b0);
    chk("sat log", {s_uncorr_count, s_log_valid, s_log_syndrome}, {4'd1, 1'b1, su.exp_syn});

    b0 = make_dec(64'hAAAA_0000_1111_2222, 2, 1, 2, 0);
    b1 = make_dec(64'h3333_4444_5555_6666, 1, 20, 0, 0);
    @(negedge clk);
    m_out_ready = 1'b1; m_in_valid = 1'b1; m_in_op = 1'b1; m_in_code = b0.code_in;
    @(negedge clk);
    m_in_code = b1.code_in;
    @(negedge clk);
    m_in_valid = 1'b0;
    chk("in flight before reset", {m_out_valid, m_log_valid}, {1'b1, 1'b1});
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 160'(m_out_valid), 160'(0));
    chk("async reset stats", {m_corr_count, m_uncorr_count, m_log_valid, m_log_syndrome, m_out_code}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post reset idle", {m_in_ready, m_out_valid}, {1'b1, 1'b0});
    do_beat(1'b0, {8'h00, 64'h0000_0000_CAFE_F00D}, lat);
    chk("post reset encode", {m_out_valid, m_out_code}, {1'b1, m_enc(64'h0000_0000_CAFE_F00D)});
    stale = 0;
    repeat (4) begin
      @(negedge clk);
      if (m_out_valid) stale++;
    end
    chk("no stale beat", 160'(stale), 160'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
